// File: rtl/nroot_fixed_engine_pkg.sv
// Shared types for the n-th root engine: FSM states, result width helper and
// the operand classes that bypass the guess search.
package nroot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIAL,
    ST_POW,
    ST_DECIDE,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SP_NONE,
    SP_N_ZERO,
    SP_N_ONE,
    SP_X_ZERO
  } special_e;

  function automatic int rw(input int iw, input int fw);
    return iw + fw;
  endfunction

  // n==0 takes priority over x==0: an undefined root saturates regardless of x.
  function automatic special_e classify(input logic n_zero, input logic n_one,
                                        input logic x_zero);
    if (n_zero) return SP_N_ZERO;
    if (n_one)  return SP_N_ONE;
    if (x_zero) return SP_X_ZERO;
    return SP_NONE;
  endfunction

endpackage

// File: rtl/nroot_fixed_engine_pow_unit.sv
// Iterative g^n in Q(IW).(FW): one truncating multiply per cycle, stopping early
// as soon as a partial product exceeds X.
module nroot_pow_unit
  import nroot_pkg::*;
#(
  parameter int IW = 10,
  parameter int FW = 10,
  parameter int EW = 3,
  localparam int RW = rw(IW, FW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [RW-1:0] g,
  input  logic [RW-1:0] x_fix,
  input  logic [EW-1:0] n,
  output logic [RW-1:0] p,
  output logic          ovf,
  output logic          done
);

  logic [RW-1:0]   p_q, p_d, g_q, g_d;
  logic [EW-1:0]   rem_q, rem_d;
  logic            ovf_q, ovf_d, run_q, run_d;
  logic [2*RW-1:0] prod, lim;
  logic            over;

  always_comb begin
    prod = {{RW{1'b0}}, p_q} * {{RW{1'b0}}, g_q};
    lim  = {{IW{1'b0}}, x_fix, {FW{1'b0}}};
    over = prod > lim;
    // done covers the multiply in flight so the caller moves on the same edge
    done = run_q & (over | (rem_q == EW'(1)));
    p_d   = p_q;
    g_d   = g_q;
    rem_d = rem_q;
    ovf_d = ovf_q;
    run_d = run_q;
    if (start) begin
      p_d   = g;
      g_d   = g;
      rem_d = n - EW'(1);
      ovf_d = 1'b0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (over) begin
        ovf_d = 1'b1;
        run_d = 1'b0;
      end else begin
        p_d   = prod[RW+FW-1:FW];
        rem_d = rem_q - EW'(1);
        if (rem_q == EW'(1)) run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q   <= '0;
      g_q   <= '0;
      rem_q <= '0;
      ovf_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      g_q   <= g_d;
      rem_q <= rem_d;
      ovf_q <= ovf_d;
      run_q <= run_d;
    end
  end

  assign p   = p_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/nroot_fixed_engine.sv
// Fixed-point n-th root: out = floor(x^(1/n)) in Q(IW).(FW), MSB-first guess search.
// Optional NROOT_EXACT_EN adds out_exact, flagging results whose n-th power equals X.
//  state  | meaning
//  IDLE   | waiting for an operand, in_ready high
//  TRIAL  | form guess res|bit, start the power unit
//  POW    | power unit iterating, wait for done
//  DECIDE | keep or drop the bit, exit on bit 0 or exact hit
//  DONE   | result presented until out_ready
module nroot_fixed_engine
  import nroot_pkg::*;
#(
  parameter int IW = 10,
  parameter int FW = 10,
  parameter int EW = 3,
  localparam int RW = rw(IW, FW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_x,
  input  logic [EW-1:0] in_n,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_data,
  output logic          busy
`ifdef NROOT_EXACT_EN
  ,
  output logic          out_exact
`endif
);

  localparam int BW = $clog2(RW);

  state_e        state_q, state_d;
  logic [RW-1:0] x_fix_q, x_fix_d, res_q, res_d, trial;
  logic [EW-1:0] n_q, n_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          exact_q, exact_d, pow_start, pow_done, pow_ovf, accept, hit;
  logic [RW-1:0] pow_p;

  nroot_pow_unit #(.IW(IW), .FW(FW), .EW(EW)) u_pow (
    .clk   (clk),
    .rst   (rst),
    .start (pow_start),
    .g     (trial),
    .x_fix (x_fix_q),
    .n     (n_q),
    .p     (pow_p),
    .ovf   (pow_ovf),
    .done  (pow_done)
  );

  always_comb begin
    trial     = res_q | (RW'(1) << bit_q);
    accept    = !pow_ovf && (pow_p <= x_fix_q);
    hit       = accept && (pow_p == x_fix_q);
    state_d   = state_q;
    x_fix_d   = x_fix_q;
    n_d       = n_q;
    res_d     = res_q;
    bit_d     = bit_q;
    exact_d   = exact_q;
    pow_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_fix_d = {in_x, {FW{1'b0}}};
          n_d     = in_n;
          res_d   = '0;
          bit_d   = BW'(RW - 1);
          exact_d = 1'b0;
          state_d = ST_DONE;
          unique case (classify(in_n == '0, in_n == EW'(1), in_x == '0))
            SP_N_ZERO: res_d = '1;
            SP_N_ONE: begin
              res_d   = {in_x, {FW{1'b0}}};
              exact_d = 1'b1;
            end
            SP_X_ZERO: exact_d = 1'b1;
            default:   state_d = ST_TRIAL;
          endcase
        end
      end
      ST_TRIAL: begin
        pow_start = 1'b1;
        state_d   = ST_POW;
      end
      ST_POW: if (pow_done) state_d = ST_DECIDE;
      ST_DECIDE: begin
        if (accept) res_d = trial;
        if (bit_q == '0 || hit) begin
          exact_d = hit;
          state_d = ST_DONE;
        end else begin
          bit_d   = bit_q - BW'(1);
          state_d = ST_TRIAL;
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_fix_q <= '0;
      n_q     <= '0;
      res_q   <= '0;
      bit_q   <= '0;
      exact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_fix_q <= x_fix_d;
      n_q     <= n_d;
      res_q   <= res_d;
      bit_q   <= bit_d;
      exact_q <= exact_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = res_q;
`ifdef NROOT_EXACT_EN
  assign out_exact = out_valid & exact_q;
`else
  logic unused_exact;
  assign unused_exact = exact_q;
`endif

endmodule

// File: tb/tb_nroot_fixed_engine.sv
// Directed and random checks of nroot_fixed_engine against a plain-arithmetic root model.
module tb_nroot_fixed_engine;

  localparam int IW = 10, FW = 10, EW = 3, RW = 20;

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [IW-1:0] in_x = '0;
  logic [EW-1:0] in_n = '0;
  logic          in_ready, out_valid, busy;
  logic [RW-1:0] out_data;
  logic          out_exact_w;
  int            compared = 0, mismatched = 0;

  nroot_fixed_engine #(.IW(IW), .FW(FW), .EW(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_n      (in_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef NROOT_EXACT_EN
    ,
    .out_exact (out_exact_w)
`endif
  );

`ifndef NROOT_EXACT_EN
  assign out_exact_w = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial search written directly from the root definition, 64-bit arithmetic.
  function automatic longint unsigned model(input int x, input int n, output bit exact);
    longint unsigned xf, res, g, p, prod;
    bit ovf;
    xf = longint'(x) << FW;
    exact = 1'b0;
    if (n == 0) return (64'd1 << RW) - 1;
    if (n == 1) begin exact = 1'b1; return xf; end
    if (x == 0) begin exact = 1'b1; return 0; end
    res = 0;
    for (int b = RW - 1; b >= 0; b--) begin
      g = res | (64'd1 << b);
      p = g;
      ovf = 1'b0;
      for (int k = 1; k < n; k++) begin
        prod = p * g;
        if (prod > (xf << FW)) begin ovf = 1'b1; break; end
        p = prod >> FW;
      end
      if (!ovf && p <= xf) begin
        res = g;
        if (p == xf) begin exact = 1'b1; break; end
      end
    end
    return res;
  endfunction

  task automatic launch(input int x, input int n);
    int w = 0;
    while (!in_ready && w < 400) begin @(negedge clk); w++; end
    check("in_ready_wait", in_ready, 1);
    in_x = IW'(x); in_n = EW'(n); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 400) begin @(negedge clk); lat++; end
    check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string tag, input int x, input int n);
    longint unsigned exp;
    bit ex;
    int lat;
    exp = model(x, n, ex);
    launch(x, n);
    wait_result(lat);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_lat"}, lat <= 2 + RW * (n + 1), 1);
`ifdef NROOT_EXACT_EN
    check({tag, "_exact"}, out_exact_w, ex);
`endif
    retire();
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);

    // directed known answers (constants, independent of the model)
    launch(4, 2); wait_result(lat);
    check("x4n2", out_data, 20'h00800);
`ifdef NROOT_EXACT_EN
    check("x4n2_exact", out_exact_w, 1);
`endif
    retire();
    launch(2, 2); wait_result(lat);
    check("x2n2", out_data, 20'h005A8);
    retire();
    launch(27, 3); wait_result(lat);
    check("x27n3", out_data, 20'h00C00);
    retire();
    launch(1023, 1); wait_result(lat);
    check("x1023n1", out_data, 20'hFFC00);
    retire();
    launch(0, 5); wait_result(lat);
    check("x0n5", out_data, 20'h00000);
    retire();
    launch(77, 0); wait_result(lat);
    check("n0", out_data, 20'hFFFFF);
    retire();

    // back-pressure: hold result 10 cycles while a new operand is offered
    launch(27, 3); wait_result(lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_x = 10'd500; in_n = 3'd2;
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 20'h00C00);
      check("bp_in_ready", in_ready, 0);
    end
    in_x = 10'd4; in_n = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_retired", out_valid, 0);
    check("bp_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_busy", busy, 1);
    wait_result(lat);
    check("bp_next_data", out_data, 20'h00800);
    retire();

    // asynchronous reset mid-search
    launch(1000, 7);
    repeat (6) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(8, 3); wait_result(lat);
    check("post_rst_x8n3", out_data, 20'h00800);
    retire();

    // boundary / model spot checks
    run_check("x1023n7", 1023, 7);
    run_check("x1n4", 1, 4);
    run_check("x2n2m", 2, 2);

    // random operands against the model
    for (int i = 0; i < 40; i++)
      run_check("rand", $urandom_range(0, 1023), $urandom_range(1, 7));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
